// File: rtl/mod9_sequence_monitor_if.sv
// Bundles the sample inputs and status outputs of the mod-9 sequence monitor.
// The master modport drives samples; the slave modport is the monitor itself.
interface mod9_sequence_monitor_if #(
    parameter int LAP_W = 8
);
    logic             i_clear;
    logic             i_en;
    logic [3:0]       i_q_in;
    logic [3:0]       o_count_out;
    logic             o_tc;
    logic             o_wrap;
    logic [LAP_W-1:0] o_lap_count;
    logic             o_lap_sat;
    logic             o_fault;
    logic [1:0]       o_err_code;

    modport master (
        output i_clear, i_en, i_q_in,
        input  o_count_out, o_tc, o_wrap, o_lap_count, o_lap_sat, o_fault, o_err_code
    );

    modport slave (
        input  i_clear, i_en, i_q_in,
        output o_count_out, o_tc, o_wrap, o_lap_count, o_lap_sat, o_fault, o_err_code
    );
endinterface

// File: rtl/mod9_sequence_monitor.sv
// Watches a mod-9 counter value stream, counts 8->0 laps (saturating) and latches
// a sticky fault on an illegal value or a broken sequence until reset or clear.
module mod9_sequence_monitor #(
    parameter int LAP_W = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    mod9_sequence_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [LAP_W-1:0] LAP_MAX  = {LAP_W{1'b1}};
    localparam logic [LAP_W-1:0] LAP_ONE  = {{(LAP_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       ERR_NONE = 2'b00;
    localparam logic [1:0]       ERR_ILL  = 2'b01;
    localparam logic [1:0]       ERR_SEQ  = 2'b10;

    // Successor of a legal mod-9 value.
    function automatic logic [3:0] f_next_value(input logic [3:0] v);
        f_next_value = (v == 4'd8) ? 4'd0 : (v + 4'd1);
    endfunction

    state_t           r_state;
    logic [3:0]       r_count_out;
    logic             r_tc;
    logic             r_wrap;
    logic [LAP_W-1:0] r_lap_count;
    logic             r_lap_sat;
    logic             r_fault;
    logic [1:0]       r_err_code;

    logic             w_illegal;
    logic             w_in_seq;
    logic             w_is_wrap;

    assign w_illegal = (bus.i_q_in > 4'd8);
    assign w_in_seq  = (bus.i_q_in == f_next_value(r_count_out));
    assign w_is_wrap = (r_count_out == 4'd8) && (bus.i_q_in == 4'd0);

    // State machine and all registered outputs; reset dominates clear, clear dominates en.
    always_ff @(posedge i_clock) begin
        if (i_reset || bus.i_clear) begin
            r_state     <= ST_INIT;
            r_count_out <= 4'd0;
            r_tc        <= 1'b0;
            r_wrap      <= 1'b0;
            r_lap_count <= {LAP_W{1'b0}};
            r_lap_sat   <= 1'b0;
            r_fault     <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (!bus.i_en) begin
                        r_state <= ST_INIT;
                    end else if (w_illegal) begin
                        r_state    <= ST_FAULT;
                        r_fault    <= 1'b1;
                        r_err_code <= ERR_ILL;
                    end else begin
                        r_state     <= ST_TRACK;
                        r_count_out <= bus.i_q_in;
                        r_tc        <= (bus.i_q_in == 4'd8);
                    end
                end
                ST_TRACK: begin
                    if (!bus.i_en) begin
                        r_state <= ST_TRACK;
                    end else if (w_illegal) begin
                        r_state    <= ST_FAULT;
                        r_fault    <= 1'b1;
                        r_err_code <= ERR_ILL;
                    end else if (w_in_seq) begin
                        r_count_out <= bus.i_q_in;
                        r_tc        <= (bus.i_q_in == 4'd8);
                        if (w_is_wrap) begin
                            r_wrap <= 1'b1;
                            if (r_lap_count != LAP_MAX) begin
                                r_lap_count <= r_lap_count + LAP_ONE;
                                // Sticky flag rises on the same edge the counter hits max.
                                if (r_lap_count == (LAP_MAX - LAP_ONE)) begin
                                    r_lap_sat <= 1'b1;
                                end else begin
                                    r_lap_sat <= r_lap_sat;
                                end
                            end else begin
                                r_lap_count <= r_lap_count;
                            end
                        end else begin
                            r_wrap <= 1'b0;
                        end
                    end else begin
                        r_state    <= ST_FAULT;
                        r_fault    <= 1'b1;
                        r_err_code <= ERR_SEQ;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.o_count_out = r_count_out;
    assign bus.o_tc        = r_tc;
    assign bus.o_wrap      = r_wrap;
    assign bus.o_lap_count = r_lap_count;
    assign bus.o_lap_sat   = r_lap_sat;
    assign bus.o_fault     = r_fault;
    assign bus.o_err_code  = r_err_code;
endmodule

// File: tb/tb_mod9_sequence_monitor.sv
// Scoreboard bench: a lap-counting reference model runs against two monitors
// (LAP_W=8 and LAP_W=2) driven by the same directed and random sample streams.
module tb_mod9_sequence_monitor;
    logic       clk = 1'b0;
    logic       t_rst = 1'b1;
    logic       t_clr = 1'b0;
    logic       t_en  = 1'b0;
    logic [3:0] t_q   = 4'd0;

    always #5 clk = ~clk;

    mod9_sequence_monitor_if #(.LAP_W(8)) bus8 ();
    mod9_sequence_monitor_if #(.LAP_W(2)) bus2 ();

    assign bus8.i_clear = t_clr;
    assign bus8.i_en    = t_en;
    assign bus8.i_q_in  = t_q;
    assign bus2.i_clear = t_clr;
    assign bus2.i_en    = t_en;
    assign bus2.i_q_in  = t_q;

    mod9_sequence_monitor #(.LAP_W(8)) dut8 (.i_clock(clk), .i_reset(t_rst), .bus(bus8));
    mod9_sequence_monitor #(.LAP_W(2)) dut2 (.i_clock(clk), .i_reset(t_rst), .bus(bus2));

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
        logic [7:0] lap8;
        logic       sat8;
        logic [1:0] lap2;
        logic       sat2;
        logic       fault;
        logic [1:0] err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: abstract state, unbounded lap tally clipped per width.
    bit         m_have  = 1'b0;
    logic [3:0] m_cnt   = 4'd0;
    logic       m_wrap  = 1'b0;
    bit         m_fault = 1'b0;
    logic [1:0] m_err   = 2'd0;
    int         m_laps  = 0;

    function automatic void model_edge(input logic rst, input logic clr,
                                       input logic e, input logic [3:0] q);
        int qi;
        int ci;
        qi = int'(q);
        ci = int'(m_cnt);
        m_wrap = 1'b0;
        if (rst || clr) begin
            m_have = 1'b0; m_cnt = 4'd0; m_fault = 1'b0; m_err = 2'd0; m_laps = 0;
        end else if (m_fault || !e) begin
            m_wrap = 1'b0;
        end else if (qi > 8) begin
            m_fault = 1'b1; m_err = 2'd1;
        end else if (!m_have) begin
            m_have = 1'b1; m_cnt = q;
        end else if (qi == (ci + 1) % 9) begin
            if (ci == 8) begin
                m_wrap = 1'b1;
                m_laps++;
            end
            m_cnt = q;
        end else begin
            m_fault = 1'b1; m_err = 2'd2;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t x;
        x.cnt   = m_cnt;
        x.tc    = (m_cnt == 4'd8);
        x.wrap  = m_wrap;
        x.lap8  = 8'((m_laps > 255) ? 255 : m_laps);
        x.sat8  = (m_laps >= 255);
        x.lap2  = 2'((m_laps > 3) ? 3 : m_laps);
        x.sat2  = (m_laps >= 3);
        x.fault = m_fault;
        x.err   = m_err;
        return x;
    endfunction

    task automatic step(input logic rst, input logic clr, input logic e, input logic [3:0] q);
        @(negedge clk);
        t_rst = rst; t_clr = clr; t_en = e; t_q = q;
        model_edge(rst, clr, e, q);
        sb_q.push_back(model_out());
    endtask

    // Monitor: after every active edge, pop the expectation for that edge and compare.
    always @(posedge clk) begin
        exp_t e;
        exp_t a8;
        exp_t a2;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a8 = e; a2 = e;
            a8.cnt = bus8.o_count_out; a8.tc = bus8.o_tc; a8.wrap = bus8.o_wrap;
            a8.lap8 = bus8.o_lap_count; a8.sat8 = bus8.o_lap_sat;
            a8.fault = bus8.o_fault; a8.err = bus8.o_err_code;
            a2.cnt = bus2.o_count_out; a2.tc = bus2.o_tc; a2.wrap = bus2.o_wrap;
            a2.lap2 = bus2.o_lap_count; a2.sat2 = bus2.o_lap_sat;
            a2.fault = bus2.o_fault; a2.err = bus2.o_err_code;
            n_checks++;
            if (a8 === e) n_pass++;
            else $display("FAIL lapw8 t=%0t got cnt=%0d tc=%b wrap=%b lap=%0d sat=%b fault=%b err=%b want cnt=%0d tc=%b wrap=%b lap=%0d sat=%b fault=%b err=%b",
                          $time, a8.cnt, a8.tc, a8.wrap, a8.lap8, a8.sat8, a8.fault, a8.err,
                          e.cnt, e.tc, e.wrap, e.lap8, e.sat8, e.fault, e.err);
            n_checks++;
            if (a2 === e) n_pass++;
            else $display("FAIL lapw2 t=%0t got cnt=%0d tc=%b wrap=%b lap=%0d sat=%b fault=%b err=%b want cnt=%0d tc=%b wrap=%b lap=%0d sat=%b fault=%b err=%b",
                          $time, a2.cnt, a2.tc, a2.wrap, a2.lap2, a2.sat2, a2.fault, a2.err,
                          e.cnt, e.tc, e.wrap, e.lap2, e.sat2, e.fault, e.err);
        end
    end

    initial begin
        logic [3:0] q;
        logic       e;
        logic       c;
        logic       r;
        // Reset, then a full lap 0..8,0,1
        step(1'b1, 1'b0, 1'b1, 4'd7);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i <= 8; i++) step(1'b0, 1'b0, 1'b1, 4'(i));
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd1);
        // Sequence break at 3 -> 5, then a legal-looking 4 is ignored
        step(1'b0, 1'b0, 1'b1, 4'd2);
        step(1'b0, 1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b1, 4'd5);
        step(1'b0, 1'b0, 1'b1, 4'd4);
        // Illegal value from INIT, clear, then restart at 6
        step(1'b0, 1'b1, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b1, 4'd12);
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd6);
        // 7,8, three idle edges with q=2, then 0 wraps
        step(1'b0, 1'b0, 1'b1, 4'd7);
        step(1'b0, 1'b0, 1'b1, 4'd8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'd2);
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd1);
        // Repeated value is a sequence break; illegal wins over sequence
        step(1'b0, 1'b0, 1'b1, 4'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd4);
        step(1'b0, 1'b0, 1'b1, 4'd9);
        // Reset and clear together with q=15
        step(1'b1, 1'b1, 1'b1, 4'd15);
        // Five-plus laps: saturates the 2-bit counter
        for (int l = 0; l < 6; l++)
            for (int i = 0; i <= 8; i++) step(1'b0, 1'b0, 1'b1, 4'(i));
        step(1'b0, 1'b0, 1'b1, 4'd0);
        // 257 laps: saturates the 8-bit counter
        step(1'b0, 1'b1, 1'b0, 4'd0);
        for (int l = 0; l < 257; l++)
            for (int i = 0; i <= 8; i++) step(1'b0, 1'b0, 1'b1, 4'(i));
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd1);
        // Random phase: mostly in-sequence samples with gaps, breaks, clears, resets
        for (int n = 0; n < 4000; n++) begin
            e = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 99) < 2);
            r = ($urandom_range(0, 199) < 1);
            if ($urandom_range(0, 99) < 90)
                q = m_have ? 4'(((int'(m_cnt) + 1) % 9)) : 4'($urandom_range(0, 8));
            else
                q = 4'($urandom_range(0, 15));
            step(r, c, e, q);
        end
        step(1'b0, 1'b0, 1'b0, 4'd0);
        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d want 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
